// File: rtl/axi_burst_seq.sv
// AXI-style burst address sequencer: accepts one command, emits one address per beat.
// Optional legality checking is enabled by defining AXI_BURST_SEQ_ERR_EN.
module axi_burst_seq #(
    parameter int unsigned AW  = 12,
    parameter int unsigned IDW = 4
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [AW-1:0]  s_addr,
    input  logic [IDW-1:0] s_id,
    input  logic [7:0]     s_len,
    input  logic [2:0]     s_size,
    input  logic [1:0]     s_burst,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [AW-1:0]  m_addr,
    output logic [IDW-1:0] m_id,
    output logic           m_last,
    output logic [7:0]     m_beat,
    output logic           busy,
    output logic           err
);

    // Headroom for wrap windows up to 128 B * 256 beats plus carry out of AW.
    localparam int unsigned W = AW + 17;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     len_q, len_d;
    logic [2:0]     size_q, size_d;
    logic [1:0]     burst_q, burst_d;
    logic [7:0]     beat_q, beat_d;

    logic [W-1:0]   bytes, addr_ext, aligned, incr, wsz, lower;
    logic [4:0]     lg;
    logic [AW-1:0]  next_addr;
    logic           cmd_err;

    function automatic logic [3:0] flog2(input logic [8:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (v[i]) r = i[3:0];
        end
        return r;
    endfunction

    // Next beat address from the latched command.
    always_comb begin
        bytes    = W'(1) << size_q;
        addr_ext = W'(addr_q);
        aligned  = addr_ext & ~(bytes - W'(1));
        incr     = aligned + bytes;
        wsz      = bytes * (W'(len_q) + W'(1));
        lg       = 5'(size_q) + 5'(flog2(9'(len_q) + 9'd1));
        lower    = addr_ext & ~((W'(1) << lg) - W'(1));
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (incr >= lower + wsz) ? lower[AW-1:0] : incr[AW-1:0];
            default: next_addr = incr[AW-1:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    addr_d  = s_addr;
                    id_d    = s_id;
                    len_d   = s_len;
                    size_d  = s_size;
                    burst_d = s_burst;
                    beat_d  = 8'd0;
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (m_ready) begin
                    if (beat_q == len_q) begin
                        state_d = StIdle;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        addr_d = next_addr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
        end
    end

    assign s_ready = (state_q == StIdle);
    assign m_valid = (state_q == StBurst);
    assign busy    = m_valid;
    assign m_addr  = addr_q;
    assign m_id    = id_q;
    assign m_beat  = beat_q;
    assign m_last  = m_valid && (beat_q == len_q);

`ifdef AXI_BURST_SEQ_ERR_EN
    logic [W-1:0] s_bytes, s_start, s_end;
    logic         err_q;

    // Command legality evaluated on the incoming fields at accept time.
    always_comb begin
        s_bytes = W'(1) << s_size;
        s_start = W'(s_addr) & ~(s_bytes - W'(1));
        s_end   = s_start + s_bytes * (W'(s_len) + W'(1)) - W'(1);
        cmd_err = (s_burst == 2'b11)
               || ((s_burst == 2'b10) && (s_len != 8'd1) && (s_len != 8'd3)
                   && (s_len != 8'd7) && (s_len != 8'd15))
               || ((AW > 12) && (s_burst == 2'b01) && ((s_start >> 12) != (s_end >> 12)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && s_valid) begin
            err_q <= cmd_err;
        end
    end

    assign err = err_q;
`else
    assign cmd_err = 1'b0;
    assign err     = cmd_err;
`endif

endmodule

// File: tb/tb_axi_burst_seq.sv
// Directed self-checking bench for axi_burst_seq (AW=12, IDW=4).
// Expected err follows whether AXI_BURST_SEQ_ERR_EN is defined for the build.
module tb_axi_burst_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_addr;
    logic [3:0]  s_id;
    logic [7:0]  s_len;
    logic [2:0]  s_size;
    logic [1:0]  s_burst;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_addr;
    logic [3:0]  m_id;
    logic        m_last;
    logic [7:0]  m_beat;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

`ifdef AXI_BURST_SEQ_ERR_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    axi_burst_seq #(.AW(12), .IDW(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_id    (s_id),
        .s_len   (s_len),
        .s_size  (s_size),
        .s_burst (s_burst),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_id    (m_id),
        .m_last  (m_last),
        .m_beat  (m_beat),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Present a command for one cycle, then scramble s_* to exercise field latching.
    task automatic issue(input logic [11:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] b);
        @(negedge clk);
        s_valid = 1'b1; s_addr = a; s_id = id; s_len = len; s_size = sz; s_burst = b;
        @(negedge clk);
        s_valid = 1'b0; s_addr = ~a; s_id = ~id; s_len = 8'hff; s_size = 3'd0; s_burst = 2'b00;
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        s_addr = '0; s_id = '0; s_len = '0; s_size = '0; s_burst = '0;
        #3;
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_addr !== 12'h000) begin n_err++; $display("FAIL rst_m_addr: got %h want 000", m_addr); end
        n_cmp++; if (m_id !== 4'h0) begin n_err++; $display("FAIL rst_m_id: got %h want 0", m_id); end
        n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last: got %b want 0", m_last); end
        n_cmp++; if (m_beat !== 8'h00) begin n_err++; $display("FAIL rst_m_beat: got %h want 00", m_beat); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_wrap();
        logic [11:0] exp [8];
        exp[0] = 12'h078; exp[1] = 12'h040; exp[2] = 12'h048; exp[3] = 12'h050;
        exp[4] = 12'h058; exp[5] = 12'h060; exp[6] = 12'h068; exp[7] = 12'h070;
        m_ready = 1'b1;
        issue(12'h078, 4'h5, 8'd7, 3'd3, 2'b10);
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d]: got %b want 1", i, m_valid); end
            n_cmp++; if (m_addr !== exp[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, m_addr, exp[i]); end
            n_cmp++; if (m_last !== (i == 7)) begin n_err++; $display("FAIL wrap_last[%0d]: got %b want %b", i, m_last, (i == 7)); end
            n_cmp++; if (m_beat !== 8'(i)) begin n_err++; $display("FAIL wrap_beat[%0d]: got %0d want %0d", i, m_beat, i); end
            n_cmp++; if (m_id !== 4'h5) begin n_err++; $display("FAIL wrap_id[%0d]: got %h want 5", i, m_id); end
            @(negedge clk);
        end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL wrap_end_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_incr();
        logic [11:0] exp [4];
        exp[0] = 12'h0FD; exp[1] = 12'h100; exp[2] = 12'h104; exp[3] = 12'h108;
        m_ready = 1'b1;
        issue(12'h0FD, 4'hA, 8'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL incr_ready[%0d]: got %b want 0", i, s_ready); end
            n_cmp++; if (m_addr !== exp[i]) begin n_err++; $display("FAIL incr_addr[%0d]: got %h want %h", i, m_addr, exp[i]); end
            n_cmp++; if (m_last !== (i == 3)) begin n_err++; $display("FAIL incr_last[%0d]: got %b want %b", i, m_last, (i == 3)); end
            @(negedge clk);
        end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL incr_end_ready: got %b want 1", s_ready); end
        n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL incr_idle_last: got %b want 0", m_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL incr_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_overflow_fixed();
        m_ready = 1'b1;
        issue(12'hFF8, 4'h1, 8'd1, 3'd3, 2'b01);
        n_cmp++; if (m_addr !== 12'hFF8) begin n_err++; $display("FAIL ovf_addr0: got %h want ff8", m_addr); end
        @(negedge clk);
        n_cmp++; if (m_addr !== 12'h000) begin n_err++; $display("FAIL ovf_addr1: got %h want 000", m_addr); end
        n_cmp++; if (m_last !== 1'b1) begin n_err++; $display("FAIL ovf_last: got %b want 1", m_last); end
        @(negedge clk);
        issue(12'h010, 4'h2, 8'd2, 3'd2, 2'b00);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (m_addr !== 12'h010) begin n_err++; $display("FAIL fixed_addr[%0d]: got %h want 010", i, m_addr); end
            n_cmp++; if (m_beat !== 8'(i)) begin n_err++; $display("FAIL fixed_beat[%0d]: got %0d want %0d", i, m_beat, i); end
            @(negedge clk);
        end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL fixed_end_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [11:0] exp [8];
        logic        pat [4];
        logic        hs;
        int          beat;
        int          cyc;
        exp[0] = 12'h078; exp[1] = 12'h040; exp[2] = 12'h048; exp[3] = 12'h050;
        exp[4] = 12'h058; exp[5] = 12'h060; exp[6] = 12'h068; exp[7] = 12'h070;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        beat = 0; cyc = 0;
        m_ready = 1'b0;
        issue(12'h078, 4'h7, 8'd7, 3'd3, 2'b10);
        while (beat < 8 && cyc < 40) begin
            m_ready = pat[cyc % 4];
            n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[c%0d]: got %b want 1", cyc, m_valid); end
            n_cmp++; if (m_addr !== exp[beat]) begin n_err++; $display("FAIL bp_addr[c%0d]: got %h want %h", cyc, m_addr, exp[beat]); end
            n_cmp++; if (m_beat !== 8'(beat)) begin n_err++; $display("FAIL bp_beat[c%0d]: got %0d want %0d", cyc, m_beat, beat); end
            n_cmp++; if (m_last !== (beat == 7)) begin n_err++; $display("FAIL bp_last[c%0d]: got %b want %b", cyc, m_last, (beat == 7)); end
            hs = m_valid && m_ready;
            @(negedge clk);
            cyc++;
            if (hs) beat++;
        end
        n_cmp++; if (beat != 8) begin n_err++; $display("FAIL bp_handshakes: got %0d want 8", beat); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL bp_end_ready: got %b want 1", s_ready); end
        m_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        issue(12'h100, 4'h3, 8'd7, 3'd2, 2'b01);
        repeat (3) @(negedge clk);
        n_cmp++; if (m_beat !== 8'd3) begin n_err++; $display("FAIL rm_beat3: got %0d want 3", m_beat); end
        #2 rstn = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b want 0", m_valid); end
        n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b want 1", s_ready); end
        n_cmp++; if (m_beat !== 8'd0) begin n_err++; $display("FAIL rm_beat: got %0d want 0", m_beat); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rm_replay: got %b want 0", m_valid); end
        issue(12'h200, 4'h9, 8'd1, 3'd2, 2'b01);
        n_cmp++; if (m_beat !== 8'd0) begin n_err++; $display("FAIL rm_new_beat: got %0d want 0", m_beat); end
        n_cmp++; if (m_addr !== 12'h200) begin n_err++; $display("FAIL rm_new_addr0: got %h want 200", m_addr); end
        n_cmp++; if (m_id !== 4'h9) begin n_err++; $display("FAIL rm_new_id: got %h want 9", m_id); end
        @(negedge clk);
        n_cmp++; if (m_addr !== 12'h204) begin n_err++; $display("FAIL rm_new_addr1: got %h want 204", m_addr); end
        n_cmp++; if (m_last !== 1'b1) begin n_err++; $display("FAIL rm_new_last: got %b want 1", m_last); end
        @(negedge clk);
    endtask

    task automatic test_err();
        int cnt;
        int cyc;
        cnt = 0; cyc = 0;
        m_ready = 1'b1;
        issue(12'h040, 4'h4, 8'd5, 3'd3, 2'b10);
        n_cmp++; if (err !== ErrExp) begin n_err++; $display("FAIL err_flag: got %b want %b", err, ErrExp); end
        while (m_valid && cyc < 20) begin
            cnt++;
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cnt != 6) begin n_err++; $display("FAIL err_beats: got %0d want 6", cnt); end
        n_cmp++; if (err !== ErrExp) begin n_err++; $display("FAIL err_sticky: got %b want %b", err, ErrExp); end
        issue(12'h010, 4'h6, 8'd0, 3'd0, 2'b01);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b want 0", err); end
        n_cmp++; if (m_last !== 1'b1) begin n_err++; $display("FAIL len0_last: got %b want 1", m_last); end
        n_cmp++; if (m_addr !== 12'h010) begin n_err++; $display("FAIL len0_addr: got %h want 010", m_addr); end
        @(negedge clk);
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL len0_done: got %b want 0", m_valid); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_incr();
        test_overflow_fixed();
        test_backpressure();
        test_reset_mid();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_burst_seq.md
AXI_BURST_SEQ -- requirements
Module: axi_burst_seq

Interface
REQ-001 Parameter AW, default 12, address width in bits.
REQ-002 Parameter IDW, default 4, transaction ID width in bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  command valid.
REQ-006 s_ready  output  1  command ready.
REQ-007 s_addr  input  AW  start address.
REQ-008 s_id  input  IDW  transaction ID.
REQ-009 s_len  input  8  beats minus 1.
REQ-010 s_size  input  3  log2 of bytes per beat.
REQ-011 s_burst  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
REQ-012 m_valid  output  1  beat address valid.
REQ-013 m_ready  input  1  beat accepted by downstream.
REQ-014 m_addr  output  AW  current beat address.
REQ-015 m_id  output  IDW  ID of the burst in progress.
REQ-016 m_last  output  1  current beat is the final beat.
REQ-017 m_beat  output  8  index of the current beat, 0 to len.
REQ-018 busy  output  1  burst in progress.
REQ-019 err  output  1  illegal-command flag (see REQ-037).

Function
REQ-020 Two states, IDLE and BURST; s_ready SHALL be 1 exactly in IDLE, m_valid SHALL be 1 exactly in BURST, and busy SHALL equal m_valid.
REQ-021 IDLE with s_valid=1: latch addr/id/len/size/burst, clear the beat counter, go to BURST; m_valid rises the next cycle with m_addr=s_addr, the unaligned start address passed unmodified.
REQ-022 BURST with m_valid&m_ready and m_beat<len: m_beat+1, m_addr SHALL become the next address (REQ-025..027), and the new value is visible the next cycle.
REQ-023 BURST with m_valid&m_ready and m_beat==len: return to IDLE; s_ready rises the next cycle (one mandatory bubble, no same-cycle accept).
REQ-024 m_ready=0 in BURST: m_addr, m_beat, m_last and m_id SHALL hold their values.
REQ-025 Define bytes=1<<size and aligned=addr with the low size bits cleared; for FIXED, next=addr.
REQ-026 INCR: next=(aligned+bytes) mod 2^AW; an AW overflow wraps silently to 0.
REQ-027 WRAP: wsz=bytes*(len+1), lower=addr with the low log2(wsz) bits cleared, and next=aligned+bytes; if next>=lower+wsz then next=lower.
REQ-028 Reserved burst 11 SHALL be sequenced as INCR.
REQ-029 m_last SHALL equal (m_beat==len) while m_valid=1, and 0 otherwise; len=0 gives a single beat with m_last=1.
REQ-030 Latched command fields SHALL be immune to s_* changes during BURST.

Reset
REQ-031 rstn low SHALL force IDLE immediately (asynchronous), regardless of the current state.
REQ-032 Reset values: s_ready=1 once in IDLE; m_valid=0, m_addr=0, m_id=0, m_last=0, m_beat=0, busy=0, err=0.
REQ-033 Reset mid-burst SHALL abandon the burst, and no beat is replayed after release.
REQ-034 After rstn deasserts, the first command SHALL be accepted on the first rising edge with s_valid=1.

Configuration
REQ-035 Macro AXI_BURST_SEQ_ERR_EN SHALL gate command legality checking.
REQ-036 Without AXI_BURST_SEQ_ERR_EN: err is tied to 0 and every command is sequenced.
REQ-037 With AXI_BURST_SEQ_ERR_EN: at accept, err is set for any of the following, and err is sticky until the next accept or reset:
- WRAP with len not in {1,3,7,15};
- burst=11;
- an INCR burst crossing a 4 KB boundary, when AW>12.
REQ-038 Flagged commands SHALL still be sequenced per REQ-025..028.

Verification
REQ-039 WRAP, addr 0x078, size 3, len 7, m_ready=1 -> m_addr sequence 0x078, 0x040, 0x048, 0x050, 0x058, 0x060, 0x068, 0x070; m_last is 1 only on 0x070.
REQ-040 INCR, addr 0x0FD, size 2, len 3 -> 0x0FD, 0x100, 0x104, 0x108; then s_ready=1 one cycle after the last handshake.
REQ-041 INCR, addr 0xFF8, size 3, len 1 -> 0xFF8, 0x000; FIXED, addr 0x010, len 2 -> 0x010 for three beats.
REQ-042 WRAP, len 7, with m_ready toggling 1,0,0,1 -> m_addr/m_beat hold while m_ready=0; 8 handshakes in total and no skipped beat.
REQ-043 Reset pulsed at beat 3 of an 8-beat INCR -> m_valid=0 and s_ready=1 immediately; the next command starts at m_beat=0.
REQ-044 With the macro defined: WRAP with len 5 -> err=1 and 6 beats issued; without the macro -> err=0.
